// File: rtl/mont_modexp_ctrl.sv
// Montgomery modular exponentiation controller: left-to-right square-and-multiply driving an external multiplier.
// Define MODEXP_SKIP_LZ_EN to skip the squarings spent on the exponent's leading zero bits.
module mont_modexp_ctrl #(
    parameter int WIDTH     = 381,
    parameter int EXP_WIDTH = 381,
    parameter int CNT_W     = 9
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [WIDTH-1:0]     in_base,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic [WIDTH-1:0]     in_m,
    input  logic [WIDTH-1:0]     in_r2,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    output logic [WIDTH-1:0]     mul_m,
    input  logic [WIDTH-1:0]     mul_result,
    input  logic                 mul_done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [2:0] {OP_TO_X, OP_TO_ACC, OP_SQ, OP_MUL, OP_OUT} op_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [CNT_W-1:0] TOP_IDX = CNT_W'(EXP_WIDTH - 1);
    localparam logic [CNT_W-1:0] IDX_ONE = CNT_W'(1);

    state_t                 state;
    op_t                    op;
    logic [WIDTH-1:0]       base_reg;
    logic [WIDTH-1:0]       r2_reg;
    logic [EXP_WIDTH-1:0]   exp_reg;
    logic [WIDTH-1:0]       xm;
    logic [WIDTH-1:0]       am;
    logic [CNT_W-1:0]       bit_idx;
`ifdef MODEXP_SKIP_LZ_EN
    logic                   seen_one;
`endif

    // mul_start and the operands are registered together out of ISSUE, so the
    // multiplier sees both in the first WAIT cycle and they stay put until mul_done.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            op        <= OP_TO_X;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_m     <= '0;
            base_reg  <= '0;
            r2_reg    <= '0;
            exp_reg   <= '0;
            xm        <= '0;
            am        <= '0;
            bit_idx   <= '0;
`ifdef MODEXP_SKIP_LZ_EN
            seen_one  <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_reg <= in_base;
                        exp_reg  <= in_exp;
                        mul_m    <= in_m;
                        r2_reg   <= in_r2;
                        op       <= OP_TO_X;
                        bit_idx  <= TOP_IDX;
`ifdef MODEXP_SKIP_LZ_EN
                        seen_one <= 1'b0;
`endif
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MODEXP_SKIP_LZ_EN
                    // Until the leading one, Am is still R mod M: squaring is a no-op and
                    // the first set bit reduces to Am = Xm.
                    if (op == OP_SQ && !seen_one) begin
                        if (exp_reg[bit_idx]) begin
                            am       <= xm;
                            seen_one <= 1'b1;
                        end
                        if (bit_idx == '0) begin
                            op <= OP_OUT;
                        end else begin
                            bit_idx <= bit_idx - IDX_ONE;
                            op      <= OP_SQ;
                        end
                    end else begin
`endif
                        mul_start <= 1'b1;
                        state     <= S_WAIT;
                        case (op)
                            OP_TO_X:   begin mul_a <= base_reg; mul_b <= r2_reg; end
                            OP_TO_ACC: begin mul_a <= ONE;      mul_b <= r2_reg; end
                            OP_SQ:     begin mul_a <= am;       mul_b <= am;     end
                            OP_MUL:    begin mul_a <= am;       mul_b <= xm;     end
                            default:   begin mul_a <= am;       mul_b <= ONE;    end
                        endcase
`ifdef MODEXP_SKIP_LZ_EN
                    end
`endif
                end
                S_WAIT: begin
                    if (mul_done) begin
                        state <= S_ISSUE;
                        case (op)
                            OP_TO_X: begin
                                xm <= mul_result;
                                op <= OP_TO_ACC;
                            end
                            OP_TO_ACC: begin
                                am <= mul_result;
                                op <= OP_SQ;
                            end
                            OP_SQ, OP_MUL: begin
                                am <= mul_result;
                                if (op == OP_SQ && exp_reg[bit_idx]) begin
                                    op <= OP_MUL;
                                end else if (bit_idx == '0) begin
                                    op <= OP_OUT;
                                end else begin
                                    bit_idx <= bit_idx - IDX_ONE;
                                    op      <= OP_SQ;
                                end
                            end
                            default: begin
                                result <= mul_result;
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                state  <= S_DONE;
                            end
                        endcase
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Bench for mont_modexp_ctrl: behavioural bit-serial Montgomery multiplier, reference modexp model and result scoreboard.
module tb_mont_modexp_ctrl;

    localparam int W       = 381;
    localparam int EW      = 381;
    localparam int MUL_LAT = 2;
    localparam logic [W-1:0] P381 = 381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [W-1:0]  in_base;
    logic [EW-1:0] in_exp;
    logic [W-1:0]  in_m;
    logic [W-1:0]  in_r2;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          mul_start;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic [W-1:0]  mul_m;
    logic [W-1:0]  mul_result;
    logic          mul_done;

    typedef struct {
        logic [W-1:0] res;
        int           muls;
    } expect_t;

    expect_t      sb[$];
    int           total = 0;
    int           bad = 0;
    int           mul_count = 0;
    logic         prev_start = 1'b0;
    logic         waiting = 1'b0;
    logic [W-1:0] a_lat, b_lat, cur_m;
    logic         inject_spur = 1'b0;
    logic [W-1:0] mdl_res;
    int           mdl_cnt;
    logic         just_done;

    always #5 clk = ~clk;

    mont_modexp_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .in_base    (in_base),
        .in_exp     (in_exp),
        .in_m       (in_m),
        .in_r2      (in_r2),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_m      (mul_m),
        .mul_result (mul_result),
        .mul_done   (mul_done)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [W-1:0] montMul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [W+1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, m};
            t = t >> 1;
        end
        if (t >= {2'b00, m}) t = t - {2'b00, m};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] modMul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        logic [2*W-1:0] p;
        logic [2*W-1:0] r;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        r = p % {{W{1'b0}}, m};
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] modexpModel(input logic [W-1:0] base, input logic [EW-1:0] e, input logic [W-1:0] m);
        logic [W-1:0] acc;
        acc = W'(1);
        for (int i = EW - 1; i >= 0; i--) begin
            acc = modMul(acc, acc, m);
            if (e[i]) acc = modMul(acc, base, m);
        end
        return acc;
    endfunction

    function automatic logic [W-1:0] r2Model(input logic [W-1:0] m);
        logic [W:0] t;
        t = (W+1)'(1);
        for (int i = 0; i < 2 * W; i++) begin
            t = t << 1;
            if (t >= {1'b0, m}) t = t - {1'b0, m};
        end
        return t[W-1:0];
    endfunction

    function automatic int expectedMuls(input logic [EW-1:0] e);
        int pc;
        int lead;
        pc = $countones(e);
        lead = 0;
        for (int i = 0; i < EW; i++) if (e[i]) lead = i;
`ifdef MODEXP_SKIP_LZ_EN
        if (pc == 0) return 3;
        return 3 + lead + pc - 1;
`else
        return 3 + EW + pc + (lead - lead);
`endif
    endfunction

    // Behavioural multiplier sharing resetn; can inject a stray mul_done right after a real one.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdl_cnt    <= 0;
            mdl_res    <= '0;
            mul_done   <= 1'b0;
            mul_result <= '0;
            just_done  <= 1'b0;
        end else begin
            mul_done  <= 1'b0;
            just_done <= 1'b0;
            if (mul_start) begin
                mdl_res <= montMul(mul_a, mul_b, mul_m);
                mdl_cnt <= MUL_LAT;
            end else if (mdl_cnt == 1) begin
                mul_done   <= 1'b1;
                mul_result <= mdl_res;
                mdl_cnt    <= 0;
                just_done  <= 1'b1;
            end else if (mdl_cnt > 1) begin
                mdl_cnt <= mdl_cnt - 1;
            end else if (just_done && inject_spur) begin
                mul_done   <= 1'b1;
                mul_result <= '1;
            end
        end
    end

    // Handshake monitor and scoreboard consumer.
    always @(negedge clk) begin
        if (!resetn) begin
            mul_count  = 0;
            waiting    = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (mul_start) begin
                checkOutput("mul_start_gap", W'(prev_start), W'(0));
                checkOutput("mul_m", mul_m, cur_m);
                mul_count++;
                a_lat   = mul_a;
                b_lat   = mul_b;
                waiting = 1'b1;
            end else if (waiting) begin
                checkOutput("mul_a_stable", mul_a, a_lat);
                checkOutput("mul_b_stable", mul_b, b_lat);
                if (mul_done) waiting = 1'b0;
            end
            prev_start = mul_start;
            if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", W'(1), W'(0));
                end else begin
                    expect_t e;
                    e = sb.pop_front();
                    checkOutput("result", result, e.res);
                    checkOutput("mul_count", W'(mul_count), W'(e.muls));
                    checkOutput("busy_at_done", W'(busy), W'(0));
                end
                mul_count = 0;
            end
        end
    end

    task automatic waitDone(input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("done_seen", W'(got), W'(1));
        @(negedge clk);
        checkOutput("done_pulse", W'(done), W'(0));
    endtask

    task automatic applyStimulus(input logic [W-1:0] base, input logic [EW-1:0] e, input logic [W-1:0] m,
                                 input logic [W-1:0] want, input logic glitch);
        expect_t x;
        x.res  = want;
        x.muls = expectedMuls(e);
        sb.push_back(x);
        @(negedge clk);
        cur_m   = m;
        in_base = base;
        in_exp  = e;
        in_m    = m;
        in_r2   = r2Model(m);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", W'(busy), W'(1));
        if (glitch) begin
            repeat (20) @(negedge clk);
            for (int i = 0; i < 200 && !mul_start; i++) @(negedge clk);
            start   = 1'b1;
            in_base = W'(5);
            in_exp  = EW'(3);
            in_m    = W'(11);
            in_r2   = '1;
            @(negedge clk);
            start = 1'b0;
        end
        waitDone(20000);
    endtask

    initial begin
        logic [W-1:0] rb;
        int           target;
        resetn  = 1'b0;
        start   = 1'b0;
        in_base = '0;
        in_exp  = '0;
        in_m    = '0;
        in_r2   = '0;
        cur_m   = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_done", W'(done), W'(0));
        checkOutput("rst_mul_start", W'(mul_start), W'(0));
        checkOutput("rst_result", result, W'(0));
        checkOutput("rst_mul_a", mul_a, W'(0));
        checkOutput("rst_mul_b", mul_b, W'(0));
        checkOutput("rst_mul_m", mul_m, W'(0));
        resetn = 1'b1;

        $display("[TB] 2^10 mod 13");
        applyStimulus(W'(2), EW'(10), W'(13), W'(10), 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("result_held", result, W'(10));

        $display("[TB] zero exponent and zero base");
        applyStimulus(W'(7), EW'(0), W'(13), W'(1), 1'b0);
        applyStimulus(W'(0), EW'(5), W'(13), W'(0), 1'b0);

        $display("[TB] Fermat inverse over P-381");
        rb = '0;
        for (int i = 0; i < 12; i++) rb = {rb[W-33:0], $urandom};
        rb = rb % P381;
        if (rb == '0) rb = W'(2);
        applyStimulus(rb, P381 - W'(2), P381, modexpModel(rb, P381 - W'(2), P381), 1'b0);
        checkOutput("fermat", modMul(result, rb, P381), W'(1));

        $display("[TB] restart during WAIT and stray mul_done");
        inject_spur = 1'b1;
        applyStimulus(W'(3), EW'(200), W'(13), modexpModel(W'(3), EW'(200), W'(13)), 1'b1);
        inject_spur = 1'b0;

        $display("[TB] reset mid-run");
`ifdef MODEXP_SKIP_LZ_EN
        target = 4;
`else
        target = 102;
`endif
        @(negedge clk);
        cur_m   = W'(13);
        in_base = W'(2);
        in_exp  = EW'(10);
        in_m    = W'(13);
        in_r2   = r2Model(W'(13));
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5000 && mul_count < target; i++) @(negedge clk);
        checkOutput("reached_target_mul", W'(mul_count), W'(target));
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", W'(busy), W'(0));
        checkOutput("midrst_done", W'(done), W'(0));
        checkOutput("midrst_mul_start", W'(mul_start), W'(0));
        checkOutput("midrst_result", result, W'(0));
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(W'(2), EW'(10), W'(13), W'(10), 1'b0);

        checkOutput("sb_leftover", W'(sb.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
